// File: rtl/ariane_soc.sv
// SoC-level constants shared by the CVA6 subsystem blocks.
package ariane_soc;
  localparam int unsigned NumCVA6     = 2;
  localparam logic [63:0] L2SPMBase   = 64'h1C00_0000;
  localparam logic [63:0] L2SPMLength = 64'h0000_8000;
endpackage

// File: rtl/l2spm_arb_pkg.sv
// Shared types and derived widths for the L2 scratchpad round-robin arbiter.
package l2spm_arb_pkg;
  localparam int unsigned MaxReq = 8;
  localparam int unsigned IdW    = $clog2(MaxReq);

  typedef struct packed {
    logic           valid;
    logic [IdW-1:0] id;
    logic           err;
  } rsp_slot_t;

  function automatic int unsigned word_off_w(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int unsigned mem_addr_w(input logic [63:0] len, input int unsigned dw);
    return $clog2(len) - $clog2(dw / 8);
  endfunction

  localparam int unsigned WordOffW = word_off_w(64);
  localparam int unsigned MemAddrW = mem_addr_w(ariane_soc::L2SPMLength, 64);
endpackage

// File: rtl/l2spm_rr_arbiter_if.sv
// Requester-side OBI bundle plus the fixed-latency SRAM port of the L2SPM arbiter.
interface l2spm_rr_arbiter_if #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MemAddrW  = 12
);
  localparam int unsigned BeW = DataWidth / 8;

  logic [NumReq-1:0]                req_i;
  logic [NumReq-1:0][63:0]          addr_i;
  logic [NumReq-1:0]                we_i;
  logic [NumReq-1:0][BeW-1:0]       be_i;
  logic [NumReq-1:0][DataWidth-1:0] wdata_i;
  logic [NumReq-1:0]                gnt_o;
  logic [NumReq-1:0]                rvalid_o;
  logic [NumReq-1:0][DataWidth-1:0] rdata_o;
  logic [NumReq-1:0]                err_o;
  logic                             mem_req_o;
  logic                             mem_we_o;
  logic [MemAddrW-1:0]              mem_addr_o;
  logic [BeW-1:0]                   mem_be_o;
  logic [DataWidth-1:0]             mem_wdata_o;
  logic [DataWidth-1:0]             mem_rdata_i;

  // master: requesters and SRAM; slave: the arbiter itself
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/l2spm_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module l2spm_rr_arbiter_rr_pick #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   idx
);
  logic [IdxW:0] pos;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      // ptr < NumReq, so one conditional subtract is enough to wrap
      pos = {1'b0, ptr} + (IdxW+1)'(k);
      if (pos >= (IdxW+1)'(NumReq)) pos = pos - (IdxW+1)'(NumReq);
      if (!found && req[pos[IdxW-1:0]]) begin
        found                = 1'b1;
        idx                  = pos[IdxW-1:0];
        gnt[pos[IdxW-1:0]]   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/l2spm_rr_arbiter.sv
// Round-robin arbiter sharing the single-port L2 scratchpad between NumReq requesters.
module l2spm_rr_arbiter
  import l2spm_arb_pkg::*;
#(
  parameter int unsigned NumReq     = ariane_soc::NumCVA6,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MemLatency = 1,
  parameter logic [63:0] BaseAddr   = ariane_soc::L2SPMBase,
  parameter logic [63:0] Length     = ariane_soc::L2SPMLength
) (
  input  logic clk_i,
  input  logic rst_i,
  l2spm_rr_arbiter_if.slave bus
);
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned WOffW = word_off_w(DataWidth);
  localparam int unsigned WinW  = $clog2(Length);

  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   win;
  logic [NumReq-1:0] pick_gnt;
  logic              any_req;
  logic              in_range;
  logic              rd_issue;
  logic [63:0]       offset;
  rsp_slot_t         issue;
  rsp_slot_t         rsp_out;
  rsp_slot_t [MemLatency-1:0] rsp_q;
  logic      [MemLatency-1:0] rd_q;
  logic              unused_id;

  l2spm_rr_arbiter_rr_pick #(.NumReq(NumReq)) u_pick (
    .req (bus.req_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (win)
  );

  // Reset gates the grant path combinationally so mem_req_o drops at once.
  assign any_req  = (|bus.req_i) && !rst_i;
  assign offset   = bus.addr_i[win] - BaseAddr;
  assign in_range = offset < Length;
  assign rd_issue = ~bus.we_i[win];

  assign bus.gnt_o       = rst_i ? '0 : pick_gnt;
  assign bus.mem_req_o   = any_req && in_range;
  assign bus.mem_we_o    = bus.mem_req_o && bus.we_i[win];
  assign bus.mem_addr_o  = bus.mem_req_o ? offset[WinW-1:WOffW] : '0;
  assign bus.mem_be_o    = bus.mem_req_o ? bus.be_i[win] : '0;
  assign bus.mem_wdata_o = bus.mem_req_o ? bus.wdata_i[win] : '0;

  always_comb begin
    issue       = '0;
    issue.valid = any_req;
    issue.id    = IdW'(win);
    issue.err   = ~in_range;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      rsp_q <= '0;
      rd_q  <= '0;
    end else begin
      rsp_q[0] <= issue;
      rd_q[0]  <= rd_issue;
      for (int unsigned k = 1; k < MemLatency; k++) begin
        rsp_q[k] <= rsp_q[k-1];
        rd_q[k]  <= rd_q[k-1];
      end
      if (any_req) ptr_q <= (win == IdxW'(NumReq-1)) ? '0 : win + 1'b1;
    end
  end

  assign rsp_out   = rsp_q[MemLatency-1];
  assign unused_id = ^rsp_out.id;

  // Writes and errors respond with zero data; idle ports always read zero.
  always_comb begin
    bus.rvalid_o = '0;
    bus.err_o    = '0;
    bus.rdata_o  = '0;
    if (rsp_out.valid) begin
      bus.rvalid_o[rsp_out.id[IdxW-1:0]] = 1'b1;
      bus.err_o[rsp_out.id[IdxW-1:0]]    = rsp_out.err;
      if (rd_q[MemLatency-1] && !rsp_out.err)
        bus.rdata_o[rsp_out.id[IdxW-1:0]] = bus.mem_rdata_i;
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_hold
    a_payload_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (bus.req_i[g] && !bus.gnt_o[g]) |=> (bus.req_i[g] && $stable(bus.addr_i[g]) &&
        $stable(bus.we_i[g]) && $stable(bus.be_i[g]) && $stable(bus.wdata_i[g])));
  end
endmodule

// File: tb/tb_l2spm_rr_arbiter.sv
// Scoreboard bench: a 4-port latency-1 arbiter and a 2-port latency-3 arbiter side by side.
module tb_l2spm_rr_arbiter;
  import l2spm_arb_pkg::*;

  localparam logic [63:0] Base = 64'h1C00_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2spm_rr_arbiter_if #(.NumReq(4), .DataWidth(64), .MemAddrW(MemAddrW)) b4 ();
  l2spm_rr_arbiter_if #(.NumReq(2), .DataWidth(64), .MemAddrW(MemAddrW)) b2 ();

  l2spm_rr_arbiter #(.NumReq(4), .DataWidth(64), .MemLatency(1)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .bus(b4));
  l2spm_rr_arbiter #(.NumReq(2), .DataWidth(64), .MemLatency(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bus(b2));

  function automatic logic [63:0] mem_word(input logic [11:0] a);
    if (a == 12'd2) return 64'hDEAD_BEEF_0000_0001;
    return {20'hC0DE0, a, 20'h00000, a};
  endfunction

  function automatic logic [63:0] waddr(input int w);
    return Base + (64'(w) << WordOffW);
  endfunction

  // SRAM models: data only for real read requests, garbage otherwise
  logic [63:0] m4_q;
  logic [63:0] m2_q [3];
  always @(posedge clk) begin
    m4_q    <= (b4.mem_req_o && !b4.mem_we_o) ? mem_word(b4.mem_addr_o) : 64'hBAD0_0000_0000_0BAD;
    m2_q[0] <= (b2.mem_req_o && !b2.mem_we_o) ? mem_word(b2.mem_addr_o) : 64'hBAD0_0000_0000_0BAD;
    m2_q[1] <= m2_q[0];
    m2_q[2] <= m2_q[1];
  end
  assign b4.mem_rdata_i = m4_q;
  assign b2.mem_rdata_i = m2_q[2];

  typedef struct {
    int          due;
    int          id;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb [2][$];

  logic [7:0]       rv_f [2];
  logic [7:0]       er_f [2];
  logic [7:0][63:0] rd_f [2];
  assign rv_f[0] = 8'(b4.rvalid_o);
  assign rv_f[1] = 8'(b2.rvalid_o);
  assign er_f[0] = 8'(b4.err_o);
  assign er_f[1] = 8'(b2.err_o);
  assign rd_f[0] = 512'(b4.rdata_o);
  assign rd_f[1] = 512'(b2.rdata_o);

  exp_t             mon_e;
  logic [7:0][63:0] mon_rd;

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (rv_f[d] != 8'h00) begin
          checks++;
          if (sb[d].size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected dut%0d cyc=%0d rvalid=%b required none", d, cyc, rv_f[d]);
          end else begin
            mon_e  = sb[d].pop_front();
            mon_rd = '0;
            mon_rd[mon_e.id] = mon_e.rdata;
            if (cyc !== mon_e.due || rv_f[d] !== 8'(1 << mon_e.id) ||
                er_f[d] !== 8'(int'(mon_e.err) << mon_e.id) || rd_f[d] !== mon_rd) begin
              errors++;
              $display("FAIL rsp dut%0d cyc=%0d rvalid=%b err=%b rdata=%h required cyc=%0d id=%0d err=%b rdata=%h",
                       d, cyc, rv_f[d], er_f[d], rd_f[d][mon_e.id], mon_e.due, mon_e.id, mon_e.err, mon_e.rdata);
            end
          end
        end else if (sb[d].size() != 0 && sb[d][0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL rsp_missing dut%0d cyc=%0d required id=%0d at cyc=%0d", d, cyc, sb[d][0].id, sb[d][0].due);
          void'(sb[d].pop_front());
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int id, input logic err, input logic [63:0] rdata);
    exp_t e;
    e.due   = cyc + ((d == 0) ? 1 : 3);
    e.id    = id;
    e.err   = err;
    e.rdata = rdata;
    sb[d].push_back(e);
  endtask

  task automatic drv4(input int r, input logic [63:0] a, input logic we, input logic [7:0] be, input logic [63:0] wd);
    b4.req_i[r] = 1'b1; b4.addr_i[r] = a; b4.we_i[r] = we; b4.be_i[r] = be; b4.wdata_i[r] = wd;
  endtask

  task automatic drv2(input int r, input logic [63:0] a);
    b2.req_i[r] = 1'b1; b2.addr_i[r] = a; b2.we_i[r] = 1'b0; b2.be_i[r] = 8'hFF; b2.wdata_i[r] = '0;
  endtask

  task automatic do_reset();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    b4.req_i = '0; b4.addr_i = '0; b4.we_i = '0; b4.be_i = '0; b4.wdata_i = '0;
    b2.req_i = '0; b2.addr_i = '0; b2.we_i = '0; b2.be_i = '0; b2.wdata_i = '0;
    rst = 1'b1;
    drv4(0, waddr(3), 1'b1, 8'hFF, 64'h1111);
    drv2(1, waddr(3));
    @(negedge clk);
    checks++;
    if ({b4.gnt_o, b4.mem_req_o, b4.mem_we_o, b4.mem_addr_o, b4.mem_be_o, b4.mem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_mem4 gnt=%b mem_req=%b we=%b addr=%h be=%h wdata=%h required all 0",
               b4.gnt_o, b4.mem_req_o, b4.mem_we_o, b4.mem_addr_o, b4.mem_be_o, b4.mem_wdata_o);
    end
    checks++;
    if ({b4.rvalid_o, b4.err_o, b4.rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_rsp4 rvalid=%b err=%b required 0", b4.rvalid_o, b4.err_o);
    end
    checks++;
    if ({b2.gnt_o, b2.mem_req_o, b2.rvalid_o, b2.err_o} !== '0) begin
      errors++;
      $display("FAIL reset_dut2 gnt=%b mem_req=%b rvalid=%b required 0", b2.gnt_o, b2.mem_req_o, b2.rvalid_o);
    end
    cycle();
    b4.req_i = '0;
    b2.req_i = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    cycle();
    drv4(0, 64'h1C00_0010, 1'b0, 8'hFF, '0);
    @(negedge clk);
    checks++;
    if (b4.gnt_o !== 4'b0001 || b4.mem_req_o !== 1'b1 || b4.mem_addr_o !== 12'd2 ||
        b4.mem_we_o !== 1'b0 || b4.mem_be_o !== 8'hFF) begin
      errors++;
      $display("FAIL single_read gnt=%b mem_req=%b addr=%0d we=%b be=%h required 0001 1 2 0 ff",
               b4.gnt_o, b4.mem_req_o, b4.mem_addr_o, b4.mem_we_o, b4.mem_be_o);
    end
    push(0, 0, 1'b0, 64'hDEAD_BEEF_0000_0001);
    cycle();
    drv4(0, 64'h1C00_0013, 1'b0, 8'hF0, '0);
    @(negedge clk);
    checks++;
    if (b4.gnt_o !== 4'b0001 || b4.mem_addr_o !== 12'd2 || b4.mem_be_o !== 8'hF0) begin
      errors++;
      $display("FAIL unaligned_read gnt=%b addr=%0d be=%h required 0001 2 f0", b4.gnt_o, b4.mem_addr_o, b4.mem_be_o);
    end
    push(0, 0, 1'b0, 64'hDEAD_BEEF_0000_0001);
    cycle();
    b4.req_i = '0;
    repeat (2) cycle();
  endtask

  task automatic test_contention();
    do_reset();
    drv4(0, waddr(4), 1'b0, 8'hFF, '0);
    drv4(1, waddr(5), 1'b0, 8'hFF, '0);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) b4.req_i[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (b4.gnt_o !== 4'(1 << (k % 2)) || b4.mem_addr_o !== 12'(4 + k % 2)) begin
        errors++;
        $display("FAIL contention step=%0d gnt=%b addr=%0d required %b %0d",
                 k, b4.gnt_o, b4.mem_addr_o, 4'(1 << (k % 2)), 4 + k % 2);
      end
      push(0, k % 2, 1'b0, mem_word(12'(4 + k % 2)));
      cycle();
    end
    b4.req_i = '0;
    repeat (2) cycle();
  endtask

  task automatic test_out_of_range();
    drv4(1, 64'h1C00_8000, 1'b1, 8'hFF, 64'h1234);
    @(negedge clk);
    checks++;
    if (b4.gnt_o !== 4'b0010 || b4.mem_req_o !== 1'b0 || b4.mem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL oor_write gnt=%b mem_req=%b we=%b required 0010 0 0", b4.gnt_o, b4.mem_req_o, b4.mem_we_o);
    end
    push(0, 1, 1'b1, '0);
    cycle();
    drv4(1, 64'h1BFF_FFF8, 1'b0, 8'hFF, '0);
    @(negedge clk);
    checks++;
    if (b4.gnt_o !== 4'b0010 || b4.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL oor_read gnt=%b mem_req=%b required 0010 0", b4.gnt_o, b4.mem_req_o);
    end
    push(0, 1, 1'b1, '0);
    cycle();
    b4.req_i[1] = 1'b0;
    drv4(2, 64'h1C00_7FF8, 1'b1, 8'h0F, 64'hCAFE_F00D_1234_5678);
    @(negedge clk);
    checks++;
    if (b4.gnt_o !== 4'b0100 || b4.mem_req_o !== 1'b1 || b4.mem_we_o !== 1'b1 || b4.mem_addr_o !== 12'hFFF ||
        b4.mem_be_o !== 8'h0F || b4.mem_wdata_o !== 64'hCAFE_F00D_1234_5678) begin
      errors++;
      $display("FAIL last_word_write gnt=%b req=%b we=%b addr=%h be=%h wdata=%h required 0100 1 1 fff 0f cafef00d12345678",
               b4.gnt_o, b4.mem_req_o, b4.mem_we_o, b4.mem_addr_o, b4.mem_be_o, b4.mem_wdata_o);
    end
    push(0, 2, 1'b0, '0);
    cycle();
    b4.req_i = '0;
    repeat (2) cycle();
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] exp_g [4];
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0001; exp_g[2] = 4'b0100; exp_g[3] = 4'b0001;
    drv4(3, waddr(9), 1'b0, 8'hFF, '0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        b4.req_i[3] = 1'b0;
        drv4(0, waddr(10), 1'b0, 8'hFF, '0);
        drv4(2, waddr(11), 1'b0, 8'hFF, '0);
      end
      if (k == 3) b4.req_i[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (b4.gnt_o !== exp_g[k]) begin
        errors++;
        $display("FAIL ptr_wrap step=%0d gnt=%b required %b", k, b4.gnt_o, exp_g[k]);
      end
      push(0, (k == 0) ? 3 : (k == 2) ? 2 : 0, 1'b0, mem_word((k == 0) ? 12'd9 : (k == 2) ? 12'd11 : 12'd10));
      cycle();
    end
    b4.req_i = '0;
    repeat (2) cycle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      drv4(1, waddr(20 + k), 1'b0, 8'hFF, '0);
      @(negedge clk);
      checks++;
      if (b4.gnt_o !== 4'b0010 || b4.mem_addr_o !== 12'(20 + k)) begin
        errors++;
        $display("FAIL back_to_back step=%0d gnt=%b addr=%0d required 0010 %0d", k, b4.gnt_o, b4.mem_addr_o, 20 + k);
      end
      push(0, 1, 1'b0, mem_word(12'(20 + k)));
      cycle();
    end
    b4.req_i = '0;
    repeat (2) cycle();
  endtask

  task automatic test_pipeline();
    for (int k = 0; k < 3; k++) begin
      drv2(0, waddr(k));
      @(negedge clk);
      checks++;
      if (b2.gnt_o !== 2'b01 || b2.mem_req_o !== 1'b1 || b2.mem_addr_o !== 12'(k)) begin
        errors++;
        $display("FAIL pipeline step=%0d gnt=%b req=%b addr=%0d required 01 1 %0d", k, b2.gnt_o, b2.mem_req_o, b2.mem_addr_o, k);
      end
      push(1, 0, 1'b0, mem_word(12'(k)));
      cycle();
    end
    b2.req_i = '0;
    repeat (5) cycle();
  endtask

  task automatic test_reset_midflight();
    drv2(0, waddr(5));
    @(negedge clk);
    checks++;
    if (b2.gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL midflight_grant gnt=%b required 01", b2.gnt_o);
    end
    cycle();
    rst = 1'b1;
    drv2(1, waddr(6));
    @(negedge clk);
    checks++;
    if (b2.gnt_o !== 2'b00 || b2.mem_req_o !== 1'b0 || b2.rvalid_o !== 2'b00) begin
      errors++;
      $display("FAIL midflight_in_reset gnt=%b mem_req=%b rvalid=%b required 00 0 00", b2.gnt_o, b2.mem_req_o, b2.rvalid_o);
    end
    cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b2.gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL midflight_after_reset gnt=%b required 01", b2.gnt_o);
    end
    push(1, 0, 1'b0, mem_word(12'd5));
    cycle();
    b2.req_i[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (b2.gnt_o !== 2'b10 || b2.rvalid_o !== 2'b00) begin
      errors++;
      $display("FAIL midflight_drop gnt=%b rvalid=%b required 10 00", b2.gnt_o, b2.rvalid_o);
    end
    push(1, 1, 1'b0, mem_word(12'd6));
    cycle();
    b2.req_i = '0;
    @(negedge clk);
    checks++;
    if (b2.rvalid_o !== 2'b00) begin
      errors++;
      $display("FAIL midflight_quiet rvalid=%b required 00", b2.rvalid_o);
    end
    repeat (5) cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_out_of_range();
    test_ptr_wrap();
    test_back_to_back();
    test_pipeline();
    test_reset_midflight();
    for (int k = 0; k < 20 && (sb[0].size() != 0 || sb[1].size() != 0); k++) cycle();
    checks++;
    if (sb[0].size() != 0 || sb[1].size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d/%0d required 0/0", sb[0].size(), sb[1].size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l2spm_rr_arbiter.md
Name: l2spm_rr_arbiter

Overview:
- Shares the single-port L2 scratchpad (L2SPMBase 0x1C00_0000, L2SPMLength 0x8000 = 32 KB) between NumReq requesters, one per CVA6 core by default.
- Provides OBI-style request/grant ports on the requester side and a fixed-latency SRAM port on the memory side.
- Arbitration is round-robin; at most one access is issued per cycle.
- Addresses outside the L2SPM window are granted but never reach the SRAM; they return an error response.

Parameters:
- NumReq, ariane_soc::NumCVA6 (2): number of requesters; legal range 1..8.
- DataWidth, 64: data bus width in bits; byte-enable width is DataWidth/8.
- MemLatency, 1: cycles from mem_req_o to mem_rdata_i valid; legal range 1..4.
- BaseAddr, ariane_soc::L2SPMBase: window base.
- Length, ariane_soc::L2SPMLength: window size in bytes; must be a power of two.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_i  in  NumReq  request valid, one bit per requester.
- addr_i  in  NumReq x 64  byte address.
- we_i  in  NumReq  1 = write.
- be_i  in  NumReq x DataWidth/8  byte enables.
- wdata_i  in  NumReq x DataWidth  write data.
- gnt_o  out  NumReq  grant, one-hot or zero.
- rvalid_o  out  NumReq  response valid.
- rdata_o  out  NumReq x DataWidth  read data.
- err_o  out  NumReq  error, qualified by rvalid_o.
- mem_req_o  out  1  SRAM access.
- mem_we_o  out  1  SRAM write.
- mem_addr_o  out  $clog2(Length/(DataWidth/8))  word index (12 bits at default).
- mem_be_o  out  DataWidth/8  SRAM byte enables.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_rdata_i  in  DataWidth  SRAM read data.

Behaviour:
- Reset values: gnt_o, rvalid_o, err_o, rdata_o and all mem_* outputs are 0; priority pointer is 0; response pipeline is empty.
- Requester protocol: a requester holds req_i and its payload stable until gnt_o. Changing the payload before grant is illegal; an assertion flags it.
- Grant: combinational in the same cycle. The winner is the first requester with req_i=1 scanning from the pointer upward, wrapping modulo NumReq.
- Pointer update: registered. On any grant the pointer becomes (winner+1) mod NumReq. With no grant it holds its value.
- In-range check: (addr_i - BaseAddr) < Length, computed with 64-bit unsigned arithmetic, so addresses below BaseAddr wrap to large values and fail the check.
- In-range access: mem_req_o=1 in the grant cycle with mem_addr_o = (addr_i - BaseAddr)[log2(Length)-1 : log2(DataWidth/8)]. mem_we_o, mem_be_o and mem_wdata_o pass through from the winner.
- Out-of-range access: gnt_o still asserts but mem_req_o stays 0. This applies to reads and writes alike.
- Unaligned addresses: low address bits are ignored; alignment is conveyed only by be_i.
- Response pipeline: a MemLatency-deep shift register of {valid, winner id, err} tracks each accepted access, so there is no response backpressure and full throughput is one access per cycle.
- Response cycle: exactly MemLatency cycles after grant, rvalid_o[id]=1 for one cycle.
  - Reads and writes both produce a response.
  - For an in-range read, rdata_o[id] = mem_rdata_i.
  - For a write or an error response, rdata_o[id] = 0.
  - err_o[id] = 1 only for an out-of-range access.
  - rdata_o for non-responding ports is 0.
- Back-to-back: a requester may re-request in the cycle after its grant; its responses stay in order.
- Simultaneous requests: exactly one grant per cycle. With all NumReq requesting continuously, each requester is granted once every NumReq cycles.
- Single requester: granted every cycle it requests, whatever the pointer value.
- Reset mid-operation: in-flight responses are dropped (no rvalid_o), the pointer returns to 0 and mem_req_o deasserts immediately (asynchronous path).

Decomposition:
- Package l2spm_arb_pkg holds rsp_slot_t {valid, id[$clog2(NumReq)], err} and the derived constants WordOffW and MemAddrW.
- BaseAddr and Length defaults come from the ariane_soc package.
- One natural sub-module, rr_pick: a combinational round-robin priority encoder with inputs req and pointer and outputs one-hot grant and winner index.
- The top level contains the pointer register, address decode, memory muxing and response shift register.

Test Plan:
- Single read at MemLatency=1: R0 reads 0x1C00_0010 with the SRAM returning 0xDEAD_BEEF_0000_0001 → gnt_o=01 in cycle 0, mem_addr_o=2, rvalid_o=01 in cycle 1 with that rdata and err=0.
- Contention: R0 and R1 request continuously from reset → grant sequence 01,10,01,10; responses alternate in the same order, one cycle later each.
- Out-of-range: R1 writes 0x1C00_8000, then reads 0x1BFF_FFF8 → both granted, mem_req_o=0 both times, rvalid_o=10 with err_o=10 and rdata=0 each time.
- Pointer wrap with NumReq=4: R3 alone is granted, then R0 and R2 request together → R0 is granted first (pointer wrapped to 0), then R2.
- MemLatency=3 pipelining: R0 issues 3 back-to-back reads to words 0,1,2 → rvalid_o asserted in cycles 3,4,5 with the matching data.
- Reset mid-flight: rst_i pulses one cycle after a grant at MemLatency=3 → no rvalid_o follows, and the next grant goes to the lowest-index requester.
